// File: rtl/tag_dequeue_ctrl.sv
// Dequeue side of the tag sort circuit: requests the minimum-tag entry from
// tag storage, then streams that packet out of the shared packet buffer.
module tag_dequeue_ctrl #(
  parameter int T      = 12,
  parameter int S      = 8,
  parameter int I      = 4,
  parameter int M      = 4,
  parameter int D      = 32,
  parameter int L      = 6,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         deq_en,
  input  logic         wr_done_mem,
  output logic         pck_addr_req,
  input  logic [T-1:0] tag_value_in,
  input  logic [S-1:0] pck_addr_in,
  input  logic [I-1:0] pck_id_in,
  output logic         spb_rd_en,
  output logic [S-1:0] spb_rd_addr,
  input  logic [D-1:0] spb_rd_data,
  output logic         eg_valid,
  input  logic         eg_ready,
  output logic [D-1:0] eg_data,
  output logic         eg_sop,
  output logic         eg_eop,
  output logic [I-1:0] eg_pck_id,
  output logic [T-1:0] vt_out,
  output logic [M:0]   occ,
  output logic         err_ovf
);

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [M:0] CAP = {1'b1, {M{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RD,
    ST_DATA,
    ST_OUT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic [S-1:0]  base_addr;
  logic [L-1:0]  idx;
  logic [L-1:0]  last_idx;
  logic [L-1:0]  len_raw;
  logic          wait_done;
  logic          is_last;

  assign len_raw   = spb_rd_data[L-1:0];
  assign wait_done = (wait_cnt <= CW'(1));
  assign is_last   = (idx == last_idx);

  assign pck_addr_req = (state == ST_REQ);
  assign spb_rd_en    = (state == ST_RD);
  assign spb_rd_addr  = spb_rd_en ? (base_addr + S'(idx)) : '0;
  assign eg_valid     = (state == ST_OUT);
  assign eg_sop       = eg_valid && (idx == '0);
  assign eg_eop       = eg_valid && is_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    // NOTE: default first, so no branch leaves state_nx unassigned and no latch is inferred.
    state_nx = state;
    unique case (state)
      ST_IDLE: if (deq_en && (occ != '0)) state_nx = ST_REQ;
      ST_REQ:  state_nx = ST_WAIT;
      ST_WAIT: if (wait_done) state_nx = ST_RD;
      ST_RD:   state_nx = ST_DATA;
      ST_DATA: state_nx = ST_OUT;
      ST_OUT:  if (eg_ready) state_nx = is_last ? ST_IDLE : ST_RD;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Simultaneous enqueue and request cancel; an enqueue into a full sorter is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ     <= '0;
      err_ovf <= 1'b0;
    end else if (wr_done_mem && !pck_addr_req) begin
      if (occ == CAP) err_ovf <= 1'b1;
      else            occ     <= occ + (M+1)'(1);
    end else if (!wr_done_mem && pck_addr_req) begin
      occ <= occ - (M+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      base_addr <= '0;
      eg_pck_id <= '0;
      vt_out    <= '0;
      idx       <= '0;
      last_idx  <= '0;
      eg_data   <= '0;
    end else begin
      unique case (state)
        ST_REQ: wait_cnt <= CW'(RD_LAT);
        ST_WAIT: begin
          if (wait_done) begin
            base_addr <= pck_addr_in;
            eg_pck_id <= pck_id_in;
            vt_out    <= tag_value_in;
            idx       <= '0;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ST_DATA: begin
          eg_data <= spb_rd_data;
          // The first word carries the length header; a zero length still sends one word.
          if (idx == '0) last_idx <= (len_raw == '0) ? '0 : (len_raw - L'(1));
        end
        ST_OUT: if (eg_ready && !is_last) idx <= idx + L'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_dequeue_ctrl.sv
// Directed bench for tag_dequeue_ctrl with behavioural tag-storage and SPB models.
module tb_tag_dequeue_ctrl;

  localparam int T = 12, S = 8, I = 4, M = 4, D = 32, L = 6, RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         deq_en = 1'b0;
  logic         wr_done_mem = 1'b0;
  logic         eg_ready = 1'b0;
  logic [T-1:0] tag_value_in = '0;
  logic [S-1:0] pck_addr_in = '0;
  logic [I-1:0] pck_id_in = '0;
  logic [D-1:0] spb_rd_data = '0;
  logic         pck_addr_req, spb_rd_en, eg_valid, eg_sop, eg_eop, err_ovf;
  logic [S-1:0] spb_rd_addr;
  logic [D-1:0] eg_data;
  logic [I-1:0] eg_pck_id;
  logic [T-1:0] vt_out;
  logic [M:0]   occ;

  int checks = 0;
  int failures = 0;

  tag_dequeue_ctrl #(.T(T), .S(S), .I(I), .M(M), .D(D), .L(L), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .deq_en(deq_en), .wr_done_mem(wr_done_mem),
    .pck_addr_req(pck_addr_req), .tag_value_in(tag_value_in), .pck_addr_in(pck_addr_in),
    .pck_id_in(pck_id_in), .spb_rd_en(spb_rd_en), .spb_rd_addr(spb_rd_addr),
    .spb_rd_data(spb_rd_data), .eg_valid(eg_valid), .eg_ready(eg_ready), .eg_data(eg_data),
    .eg_sop(eg_sop), .eg_eop(eg_eop), .eg_pck_id(eg_pck_id), .vt_out(vt_out),
    .occ(occ), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Storage returns its entry exactly two cycles after the request; SPB data is
  // valid only in the cycle after the read strobe. Everything else is junk.
  logic [D-1:0] mem [256];
  logic [T-1:0] st_tag = '0;
  logic [S-1:0] st_addr = '0;
  logic [I-1:0] st_id = '0;
  logic         h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic         last_en = 1'b0;
  logic [S-1:0] last_addr = '0;

  always @(negedge clk) begin
    h2 = h1; h1 = h0; h0 = pck_addr_req;
    if (h2) begin
      tag_value_in = st_tag; pck_addr_in = st_addr; pck_id_in = st_id;
    end else begin
      tag_value_in = '1; pck_addr_in = '1; pck_id_in = '1;
    end
    spb_rd_data = last_en ? mem[last_addr] : 32'hDEAD_BEEF;
    last_en = spb_rd_en;
    last_addr = spb_rd_addr;
  end

  int           req_count = 0;
  logic [S-1:0] rd_log[$];
  logic [D-1:0] eg_d_q[$];
  logic         eg_sop_q[$], eg_eop_q[$];
  logic [I-1:0] eg_id_q[$];

  always @(posedge clk) begin
    if (pck_addr_req) req_count++;
    if (spb_rd_en) rd_log.push_back(spb_rd_addr);
    if (eg_valid && eg_ready) begin
      eg_d_q.push_back(eg_data);
      eg_sop_q.push_back(eg_sop);
      eg_eop_q.push_back(eg_eop);
      eg_id_q.push_back(eg_pck_id);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); eg_d_q.delete(); eg_sop_q.delete(); eg_eop_q.delete(); eg_id_q.delete();
  endtask

  task automatic wait_req(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = pck_addr_req;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_req: pck_addr_req not seen within 20 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = eg_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_valid: eg_valid not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_words(input string name, input int n, input int budget);
    for (int i = 0; i < budget && eg_d_q.size() < n; i++) step();
    checks++;
    if (eg_d_q.size() < n) begin
      failures++;
      $display("FAIL %s_words: got %0d words, need %0d", name, eg_d_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; deq_en = 1'b1;
    repeat (3) step();
    checks++;
    if ({pck_addr_req, spb_rd_en, eg_valid, eg_sop, eg_eop, err_ovf} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl: req/rd/valid/sop/eop/ovf=%b, need 000000",
               {pck_addr_req, spb_rd_en, eg_valid, eg_sop, eg_eop, err_ovf});
    end
    checks++;
    if (occ !== '0 || vt_out !== '0 || eg_data !== '0 || eg_pck_id !== '0 || spb_rd_addr !== '0) begin
      failures++;
      $display("FAIL reset_data: occ=%0d vt=%h data=%h id=%0d addr=%h, need all 0",
               occ, vt_out, eg_data, eg_pck_id, spb_rd_addr);
    end
    rst = 1'b1;
    repeat (6) step();
    checks++;
    if (req_count !== 0) begin
      failures++;
      $display("FAIL reset_noreq: %0d requests with occ=0, need 0", req_count);
    end
    deq_en = 1'b0;
  endtask

  task automatic test_basic();
    int lat = 0;
    logic [S-1:0] a;
    mem[8'h10] = 32'hA5A5_0003; mem[8'h11] = 32'h1111_2222; mem[8'h12] = 32'h3333_4444;
    st_tag = 12'h05A; st_addr = 8'h10; st_id = 4'd3;
    clear_logs();
    repeat (3) begin wr_done_mem = 1'b1; step(); end
    wr_done_mem = 1'b0;
    checks++;
    if (occ !== 5'd3) begin failures++; $display("FAIL basic_occ3: occ=%0d, need 3", occ); end
    eg_ready = 1'b1; deq_en = 1'b1;
    wait_req("basic");
    deq_en = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (eg_valid) lat = i;
    end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL basic_latency: %0d cycles, need 5", lat); end
    checks++;
    if (occ !== 5'd2) begin failures++; $display("FAIL basic_occ2: occ=%0d, need 2", occ); end
    wait_words("basic", 3, 30);
    repeat (4) step();
    checks++;
    if (eg_d_q.size() !== 3 || rd_log.size() !== 3) begin
      failures++;
      $display("FAIL basic_count: words=%0d reads=%0d, need 3 and 3", eg_d_q.size(), rd_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      a = S'(8'h10 + i);
      checks++;
      if ({rd_log[i], eg_d_q[i], eg_sop_q[i], eg_eop_q[i], eg_id_q[i]} !==
          {a, mem[a], i == 0, i == 2, 4'd3}) begin
        failures++;
        $display("FAIL basic_word%0d: addr=%h data=%h sop=%b eop=%b id=%0d, need addr=%h data=%h sop=%b eop=%b id=3",
                 i, rd_log[i], eg_d_q[i], eg_sop_q[i], eg_eop_q[i], eg_id_q[i], a, mem[a], i == 0, i == 2);
      end
    end
    checks++;
    if (vt_out !== 12'h05A || req_count !== 1) begin
      failures++;
      $display("FAIL basic_vt: vt=%h requests=%0d, need 05a and 1", vt_out, req_count);
    end
  endtask

  task automatic test_wrap();
    logic [S-1:0] a;
    mem[8'hFE] = 32'h0BAD_F004; mem[8'hFF] = 32'h0000_00FF;
    mem[8'h00] = 32'h0000_0100; mem[8'h01] = 32'h0000_0101;
    st_tag = 12'h0A0; st_addr = 8'hFE; st_id = 4'd7;
    clear_logs();
    eg_ready = 1'b1; deq_en = 1'b1;
    wait_req("wrap");
    deq_en = 1'b0;
    wait_words("wrap", 4, 40);
    repeat (4) step();
    checks++;
    if (eg_d_q.size() !== 4) begin failures++; $display("FAIL wrap_count: words=%0d, need 4", eg_d_q.size()); end
    for (int i = 0; i < 4; i++) begin
      a = S'(8'hFE + i);
      checks++;
      if ({rd_log[i], eg_d_q[i], eg_sop_q[i], eg_eop_q[i], eg_id_q[i]} !==
          {a, mem[a], i == 0, i == 3, 4'd7}) begin
        failures++;
        $display("FAIL wrap_word%0d: addr=%h data=%h sop=%b eop=%b id=%0d, need addr=%h data=%h",
                 i, rd_log[i], eg_d_q[i], eg_sop_q[i], eg_eop_q[i], eg_id_q[i], a, mem[a]);
      end
    end
    checks++;
    if (vt_out !== 12'h0A0 || occ !== 5'd1) begin
      failures++;
      $display("FAIL wrap_state: vt=%h occ=%0d, need 0a0 and 1", vt_out, occ);
    end
  endtask

  task automatic test_backpressure();
    logic [D-1:0] held;
    int           nrd;
    bit           stable = 1;
    mem[8'h20] = 32'h0000_0043; mem[8'h21] = 32'h2121_2121; mem[8'h22] = 32'h2222_2222;
    st_tag = 12'h0B0; st_addr = 8'h20; st_id = 4'd9;
    clear_logs();
    eg_ready = 1'b0; deq_en = 1'b1;
    wait_req("stall");
    deq_en = 1'b0;
    wait_valid("stall_w0", 20);
    eg_ready = 1'b1;
    step();
    eg_ready = 1'b0;
    wait_valid("stall_w1", 10);
    held = eg_data;
    nrd = rd_log.size();
    repeat (10) begin
      step();
      if (!eg_valid || eg_data !== held || eg_sop !== 1'b0 || eg_eop !== 1'b0) stable = 0;
    end
    checks++;
    if (held !== mem[8'h21]) begin
      failures++;
      $display("FAIL stall_data: held=%h, need %h", held, mem[8'h21]);
    end
    checks++;
    if (!stable || rd_log.size() !== nrd) begin
      failures++;
      $display("FAIL stall_hold: stable=%b reads %0d->%0d, need stable=1 and no new read",
               stable, nrd, rd_log.size());
    end
    eg_ready = 1'b1;
    wait_words("stall", 3, 30);
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({eg_d_q[i], eg_sop_q[i], eg_eop_q[i]} !== {mem[S'(8'h20 + i)], i == 0, i == 2}) begin
        failures++;
        $display("FAIL stall_word%0d: data=%h sop=%b eop=%b, need data=%h",
                 i, eg_d_q[i], eg_sop_q[i], eg_eop_q[i], mem[S'(8'h20 + i)]);
      end
    end
    checks++;
    if (occ !== 5'd0) begin failures++; $display("FAIL stall_occ: occ=%0d, need 0", occ); end
  endtask

  task automatic test_occupancy();
    mem[8'h30] = 32'h0000_0001;
    st_tag = 12'h0C0; st_addr = 8'h30; st_id = 4'd2;
    clear_logs();
    wr_done_mem = 1'b1; step(); wr_done_mem = 1'b0;
    deq_en = 1'b1;
    step();
    checks++;
    if (pck_addr_req !== 1'b1) begin
      failures++;
      $display("FAIL occ_req: pck_addr_req=%b one cycle after deq_en, need 1", pck_addr_req);
    end
    wr_done_mem = 1'b1; deq_en = 1'b0;
    step();
    wr_done_mem = 1'b0;
    checks++;
    if (occ !== 5'd1) begin failures++; $display("FAIL occ_same_cycle: occ=%0d, need 1", occ); end
    eg_ready = 1'b1;
    wait_words("occ", 1, 30);
    repeat (4) step();
    repeat (15) begin wr_done_mem = 1'b1; step(); end
    wr_done_mem = 1'b0;
    checks++;
    if (occ !== 5'd16 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL occ_full: occ=%0d ovf=%b, need 16 and 0", occ, err_ovf);
    end
    wr_done_mem = 1'b1; step(); wr_done_mem = 1'b0;
    step();
    checks++;
    if (occ !== 5'd16 || err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL occ_ovf: occ=%0d ovf=%b, need 16 and 1", occ, err_ovf);
    end
  endtask

  task automatic test_len_zero();
    mem[8'h40] = 32'hCAFE_0000;
    st_tag = 12'h0D0; st_addr = 8'h40; st_id = 4'd5;
    clear_logs();
    eg_ready = 1'b1; deq_en = 1'b1;
    wait_req("len0");
    deq_en = 1'b0;
    wait_words("len0", 1, 30);
    repeat (6) step();
    checks++;
    if (eg_d_q.size() !== 1 || rd_log.size() !== 1) begin
      failures++;
      $display("FAIL len0_count: words=%0d reads=%0d, need 1 and 1", eg_d_q.size(), rd_log.size());
    end
    checks++;
    if ({rd_log[0], eg_d_q[0], eg_sop_q[0], eg_eop_q[0], eg_id_q[0]} !==
        {8'h40, 32'hCAFE_0000, 1'b1, 1'b1, 4'd5}) begin
      failures++;
      $display("FAIL len0_word: addr=%h data=%h sop=%b eop=%b id=%0d, need 40 cafe0000 1 1 5",
               rd_log[0], eg_d_q[0], eg_sop_q[0], eg_eop_q[0], eg_id_q[0]);
    end
    checks++;
    if (occ !== 5'd15 || vt_out !== 12'h0D0) begin
      failures++;
      $display("FAIL len0_state: occ=%0d vt=%h, need 15 and 0d0", occ, vt_out);
    end
  endtask

  task automatic test_reset_mid_packet();
    int nrd;
    int nreq;
    mem[8'h50] = 32'h0000_0005;
    st_tag = 12'h0E0; st_addr = 8'h50; st_id = 4'd6;
    clear_logs();
    eg_ready = 1'b0; deq_en = 1'b1;
    wait_req("abort");
    deq_en = 1'b0;
    wait_valid("abort", 20);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({eg_valid, eg_sop, eg_eop, err_ovf} !== 4'b0 || occ !== '0 || vt_out !== '0) begin
      failures++;
      $display("FAIL abort_async: valid/sop/eop/ovf=%b occ=%0d vt=%h, need 0000 0 000",
               {eg_valid, eg_sop, eg_eop, err_ovf}, occ, vt_out);
    end
    step();
    rst = 1'b1;
    nrd = rd_log.size();
    nreq = req_count;
    eg_ready = 1'b1; deq_en = 1'b1;
    repeat (8) step();
    checks++;
    if (rd_log.size() !== nrd || req_count !== nreq || eg_d_q.size() !== 0 || eg_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: reads %0d->%0d reqs %0d->%0d words=%0d valid=%b, need no activity",
               nrd, rd_log.size(), nreq, req_count, eg_d_q.size(), eg_valid);
    end
    deq_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_occupancy();
    test_len_zero();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_dequeue_ctrl.md
Name: tag_dequeue_ctrl

Overview:
- Consumer side of the tag sort circuit: pulls the minimum-tag entry from the tag storage and streams that packet out of the shared packet buffer (SPB).
- Tracks sorter occupancy from enqueue-completion pulses and issues one read request per packet.
- Fetches the packet words from the SPB and presents them on a valid/ready egress port.
- Keeps the scheduler virtual time equal to the tag of the packet being served.

Parameters:
- T, 12: tag value width
- S, 8: SPB address width
- I, 4: packet ID width
- M, 4: storage address width; sorter capacity is 2^M entries
- D, 32: SPB data word width
- L, 6: packet length field width, in words
- RD_LAT, 2: cycles from the pck_addr_req pulse to valid tag_value_in, pck_addr_in and pck_id_in

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- deq_en  in  1  dequeue permission from the egress scheduler
- wr_done_mem  in  1  one-cycle pulse when an entry is committed to tag storage
- pck_addr_req  out  1  one-cycle read request to tag storage
- tag_value_in  in  T  minimum tag returned by storage
- pck_addr_in  in  S  SPB base address of that packet
- pck_id_in  in  I  packet ID of that packet
- spb_rd_en  out  1  SPB read strobe
- spb_rd_addr  out  S  SPB read address
- spb_rd_data  in  D  SPB read data, valid the cycle after spb_rd_en
- eg_valid  out  1  egress word valid
- eg_ready  in  1  egress accept
- eg_data  out  D  egress word
- eg_sop  out  1  first word of packet
- eg_eop  out  1  last word of packet
- eg_pck_id  out  I  ID of the packet on egress
- vt_out  out  T  virtual time (tag of last dequeued packet)
- occ  out  M+1  entries currently held in the sorter
- err_ovf  out  1  sticky: enqueue pulse arrived while occ=2^M

Behaviour:
- Reset: all outputs and registers are 0, FSM in IDLE. Asserting reset mid-packet aborts the packet immediately with no eg_eop.
- Occupancy:
  - occ +1 on wr_done_mem, -1 on pck_addr_req; both in the same cycle leaves occ unchanged.
  - wr_done_mem with occ=2^M and no request sets err_ovf and occ holds.
  - pck_addr_req is never issued with occ=0.
- FSM states and transitions:
  - IDLE: go to REQ when deq_en=1 and occ!=0.
  - REQ: pck_addr_req=1 for exactly one cycle; load the wait counter with RD_LAT; go to WAIT.
  - WAIT: count down; on reaching 0, register tag_value_in, pck_addr_in and pck_id_in, set vt_out<=tag_value_in, clear word index idx to 0, go to RD.
  - RD: spb_rd_en=1, spb_rd_addr = base+idx, mod 2^S (the address wraps); go to DATA.
  - DATA: capture spb_rd_data into eg_data. If idx=0, latch len = spb_rd_data[L-1:0]; len=0 is treated as 1. Go to OUT.
  - OUT: eg_valid=1. eg_sop=(idx==0). eg_eop=(idx==len-1). eg_pck_id = latched ID.
    - eg_data, sop, eop and ID stay stable until eg_ready=1.
    - On accept: if eop, go to IDLE; else idx+1 and go to RD.
- Throughput is one word per 3 cycles when eg_ready is held at 1. Minimum latency from IDLE exit to first eg_valid is RD_LAT+3 cycles.
- deq_en deasserting mid-packet does not stop the packet; it only gates the next IDLE->REQ transition.
- vt_out changes only in WAIT on capture; it holds its value through IDLE.
- At most one packet is in flight at a time. IDLE is re-entered for at least one cycle between packets.

Test Plan:
- Reset with RD_LAT=2 and no traffic: all outputs 0, pck_addr_req never asserts even with deq_en=1.
- Three wr_done_mem pulses, deq_en=1, storage returns tag=0x05A, addr=0x10, id=3; SPB[0x10] low bits=3, eg_ready=1 -> single pck_addr_req; first eg_valid 5 cycles after leaving IDLE; 3 words from addresses 0x10, 0x11, 0x12 with sop on word 0 and eop on word 2; eg_pck_id=3; vt_out=0x05A; occ goes 3 -> 2.
- Packet with base addr=0xFE and len=4 -> reads 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
- eg_ready held 0 for 10 cycles on word 1 -> eg_valid stays 1 with eg_data stable and no new spb_rd_en; the transfer resumes when eg_ready=1.
- wr_done_mem in the same cycle as pck_addr_req at occ=1 -> occ stays 1. With occ=16 (M=4), an extra wr_done_mem -> err_ovf=1 and occ=16.
- Header len=0 -> a single word with sop=eop=1. rst=0 pulsed mid-packet -> eg_valid drops asynchronously, occ=0, FSM in IDLE.
